fetch_pc_gen: RTL and testbench

//  Fetch-side PC generator: the receiving end of the flush_t redirect protocol issued by

---
 rtl/com_pkg.sv | 41 ++++
 rtl/fetch_btb.sv | 72 +++++++
 rtl/fetch_pc_gen.sv | 204 ++++++++++++++++++++
 tb/tb_fetch_pc_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/com_pkg.sv
// Shared types for the fetch front end: the flush_t redirect record, the
// fetch request bundle handed to decode1/decode2 and the BTB entry layout.
package com_pkg;

  // Architectural address width used by all shared structs.
  localparam int COM_ADDR_W    = 32;
  // Width of the redirect epoch tag carried with each fetch request.
  localparam int FETCH_EPOCH_W = 2;

  // Redirect request issued by decode2 or by the back end.
  typedef struct packed {
    logic                  valid;
    logic [COM_ADDR_W-1:0] address;
  } flush_t;

  // One fetch request as seen by instruction memory and the decoders.
  typedef struct packed {
    logic [COM_ADDR_W-1:0]    pc;
    logic [COM_ADDR_W-1:0]    pred_next;
    logic                     branch_jump;
    logic [FETCH_EPOCH_W-1:0] epoch;
  } fetch_req_t;

  // Branch target buffer entry; the tag is kept right-aligned in a full-width field.
  typedef struct packed {
    logic                  valid;
    logic [COM_ADDR_W-1:0] tag;
    logic [COM_ADDR_W-1:0] target;
  } btb_entry_t;

  // Force an address onto a 4-byte instruction boundary.
  function automatic logic [COM_ADDR_W-1:0] word_align(input logic [COM_ADDR_W-1:0] addr);
    return {addr[COM_ADDR_W-1:2], 2'b00};
  endfunction

  // Even parity over an address, handy for protecting stored PCs.
  function automatic logic addr_parity(input logic [COM_ADDR_W-1:0] addr);
    return ^addr;
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer for fetch_pc_gen.
// Index is pc[log2(ENTRIES)+1:2]; the tag is every address bit above the index.
// Lookup is combinational from the current fetch PC; a training write is only
// visible to lookup from the following cycle. Used when FETCH_BTB_EN is defined.
module fetch_btb
  import com_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] lookup_pc,
  output logic             hit,
  output logic [WIDTH-1:0] target,
  input  logic             train_en,
  input  logic             train_set,
  input  logic [WIDTH-1:0] train_pc,
  input  logic [WIDTH-1:0] train_target
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  btb_entry_t             mem_r [ENTRIES];
  logic [IDX_W-1:0]       lookup_idx_s;
  logic [IDX_W-1:0]       train_idx_s;
  btb_entry_t             lookup_entry_s;
  logic [1:0]             unused_lo_s;

  // Tag: address with the index and byte-offset bits shifted away.
  function automatic logic [COM_ADDR_W-1:0] tag_of(input logic [WIDTH-1:0] pc);
    return COM_ADDR_W'(pc >> (IDX_W + 2));
  endfunction

  assign lookup_idx_s = lookup_pc[IDX_W+1:2];
  assign train_idx_s  = train_pc[IDX_W+1:2];
  assign unused_lo_s  = lookup_pc[1:0] ^ train_pc[1:0];

  // Read the indexed entry and compare its tag against the fetch PC.
  always_comb begin
    lookup_entry_s = mem_r[lookup_idx_s];
    hit            = 1'b0;
    target         = lookup_entry_s.target[WIDTH-1:0];
    if (lookup_entry_s.valid && (lookup_entry_s.tag == tag_of(lookup_pc))) begin
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end
  end

  // Storage: cleared on reset, written or invalidated by decode2 training.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_r[i] <= '0;
      end
    end else if (train_en) begin
      if (train_set) begin
        mem_r[train_idx_s].valid  <= 1'b1;
        mem_r[train_idx_s].tag    <= tag_of(train_pc);
        mem_r[train_idx_s].target <= COM_ADDR_W'({train_target[WIDTH-1:2], 2'b00});
      end else begin
        mem_r[train_idx_s].valid  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_r[i] <= mem_r[i];
      end
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-side PC generator. Holds the fetch PC, offers one request per cycle to
// instruction memory and applies redirects with priority
//   ex_flush > pending redirect > dec_flush > advance > hold.
// While clk_en is low all state holds, but any incoming flush is parked in a
// one-entry pending redirect so it is not lost.
// Optional feature macro: FETCH_BTB_EN adds a direct-mapped BTB (fetch_btb) that
// supplies predicted targets; without it the prediction is always pc+4.
module fetch_pc_gen
  import com_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int               BTB_ENTRIES  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic                     stall,
  input  flush_t                   ex_flush,
  input  flush_t                   dec_flush,
  input  logic [WIDTH-1:0]         dec_pc,
  input  logic                     dec_is_jump,
  input  logic                     fetch_ready,
  output logic                     fetch_valid,
  output logic [WIDTH-1:0]         fetch_pc,
  output logic [WIDTH-1:0]         fetch_pred_next,
  output logic                     fetch_branch_jump,
  output logic [FETCH_EPOCH_W-1:0] fetch_epoch
);

  logic [WIDTH-1:0]         pc_r;
  logic                     valid_r;
  logic [FETCH_EPOCH_W-1:0] epoch_r;

  // One-entry redirect parked while clk_en is low.
  logic                     pend_valid_r;
  logic                     pend_is_ex_r;
  logic [WIDTH-1:0]         pend_addr_r;

  logic                     redirect_s;
  logic [WIDTH-1:0]         redir_addr_s;
  logic                     advance_s;
  logic [WIDTH-1:0]         pc_plus4_s;
  logic                     btb_hit_s;
  logic [WIDTH-1:0]         btb_target_s;
  fetch_req_t               req_s;

  assign pc_plus4_s = pc_r + WIDTH'(32'd4);

`ifdef FETCH_BTB_EN
  // A parked decode redirect keeps its training information with it.
  logic                     pend_dec_jump_r;
  logic [WIDTH-1:0]         pend_dec_pc_r;
  logic                     dec_apply_s;
  logic                     train_set_s;
  logic [WIDTH-1:0]         train_pc_s;
  logic                     train_en_s;
  logic [31:0]              unused_ok_s;

  assign unused_ok_s = 32'(BTB_ENTRIES);
  assign train_en_s  = clk_en && dec_apply_s;

  fetch_btb #(
    .WIDTH   (WIDTH),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .rst          (rst),
    .lookup_pc    (pc_r),
    .hit          (btb_hit_s),
    .target       (btb_target_s),
    .train_en     (train_en_s),
    .train_set    (train_set_s),
    .train_pc     (train_pc_s),
    .train_target (redir_addr_s)
  );
`else
  logic [WIDTH+32:0]        unused_ok_s;

  assign unused_ok_s  = {dec_pc, dec_is_jump, 32'(BTB_ENTRIES)};
  assign btb_hit_s    = 1'b0;
  assign btb_target_s = '0;
`endif

  // Pick the winning redirect source for this cycle, if any.
  always_comb begin
    redirect_s   = 1'b0;
    redir_addr_s = '0;
`ifdef FETCH_BTB_EN
    dec_apply_s  = 1'b0;
    train_set_s  = dec_is_jump;
    train_pc_s   = dec_pc;
`endif
    if (ex_flush.valid) begin
      redirect_s   = 1'b1;
      redir_addr_s = ex_flush.address[WIDTH-1:0];
    end else if (pend_valid_r) begin
      redirect_s   = 1'b1;
      redir_addr_s = pend_addr_r;
`ifdef FETCH_BTB_EN
      dec_apply_s  = !pend_is_ex_r;
      train_set_s  = pend_dec_jump_r;
      train_pc_s   = pend_dec_pc_r;
`endif
    end else if (dec_flush.valid) begin
      redirect_s   = 1'b1;
      redir_addr_s = dec_flush.address[WIDTH-1:0];
`ifdef FETCH_BTB_EN
      dec_apply_s  = 1'b1;
`endif
    end else begin
      redirect_s   = 1'b0;
    end
    advance_s = valid_r && fetch_ready && !stall && !redirect_s;
  end

  // Prediction is a pure function of the current PC and BTB contents.
  always_comb begin
    req_s.pc          = COM_ADDR_W'(pc_r);
    req_s.epoch       = epoch_r;
    if (btb_hit_s) begin
      req_s.pred_next   = COM_ADDR_W'(btb_target_s);
      req_s.branch_jump = 1'b1;
    end else begin
      req_s.pred_next   = COM_ADDR_W'(pc_plus4_s);
      req_s.branch_jump = 1'b0;
    end
  end

  assign fetch_valid       = valid_r;
  assign fetch_pc          = req_s.pc[WIDTH-1:0];
  assign fetch_epoch       = req_s.epoch;
  assign fetch_pred_next   = req_s.pred_next[WIDTH-1:0];
  assign fetch_branch_jump = req_s.branch_jump;

  // PC, valid and epoch: redirect, advance or hold; frozen while clk_en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r    <= RESET_VECTOR;
      valid_r <= 1'b0;
      epoch_r <= '0;
    end else if (clk_en) begin
      valid_r <= 1'b1;
      if (redirect_s) begin
        pc_r    <= {redir_addr_s[WIDTH-1:2], 2'b00};
        epoch_r <= epoch_r + FETCH_EPOCH_W'(1);
      end else if (advance_s) begin
        pc_r    <= req_s.pred_next[WIDTH-1:0];
        epoch_r <= epoch_r;
      end else begin
        pc_r    <= pc_r;
        epoch_r <= epoch_r;
      end
    end else begin
      pc_r    <= pc_r;
      valid_r <= valid_r;
      epoch_r <= epoch_r;
    end
  end

  // Pending redirect: captured while clk_en is low, consumed on the next enabled cycle.
  // A back-end flush always overwrites; a decode flush never displaces a parked back-end one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid_r <= 1'b0;
      pend_is_ex_r <= 1'b0;
      pend_addr_r  <= '0;
    end else if (clk_en) begin
      pend_valid_r <= 1'b0;
      pend_is_ex_r <= 1'b0;
      pend_addr_r  <= pend_addr_r;
    end else if (ex_flush.valid) begin
      pend_valid_r <= 1'b1;
      pend_is_ex_r <= 1'b1;
      pend_addr_r  <= ex_flush.address[WIDTH-1:0];
    end else if (dec_flush.valid && !(pend_valid_r && pend_is_ex_r)) begin
      pend_valid_r <= 1'b1;
      pend_is_ex_r <= 1'b0;
      pend_addr_r  <= dec_flush.address[WIDTH-1:0];
    end else begin
      pend_valid_r <= pend_valid_r;
      pend_is_ex_r <= pend_is_ex_r;
      pend_addr_r  <= pend_addr_r;
    end
  end

`ifdef FETCH_BTB_EN
  // Training information that travels with a parked decode redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_dec_jump_r <= 1'b0;
      pend_dec_pc_r   <= '0;
    end else if (!clk_en && !ex_flush.valid && dec_flush.valid &&
                 !(pend_valid_r && pend_is_ex_r)) begin
      pend_dec_jump_r <= dec_is_jump;
      pend_dec_pc_r   <= dec_pc;
    end else begin
      pend_dec_jump_r <= pend_dec_jump_r;
      pend_dec_pc_r   <= pend_dec_pc_r;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen. Expected request fields are pushed to a
// scoreboard queue when stimulus is driven and compared one cycle later.
// Define FETCH_BTB_EN for both bench and RTL to exercise the BTB steps.
module tb_fetch_pc_gen;
  import com_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        stall;
  flush_t      ex_flush;
  flush_t      dec_flush;
  logic [31:0] dec_pc;
  logic        dec_is_jump;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pred_next;
  logic        fetch_branch_jump;
  logic [1:0]  fetch_epoch;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] pn;
    logic        bj;
    logic [1:0]  ep;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  fetch_pc_gen dut (
    .clk               (clk),
    .rst               (rst),
    .clk_en            (clk_en),
    .stall             (stall),
    .ex_flush          (ex_flush),
    .dec_flush         (dec_flush),
    .dec_pc            (dec_pc),
    .dec_is_jump       (dec_is_jump),
    .fetch_ready       (fetch_ready),
    .fetch_valid       (fetch_valid),
    .fetch_pc          (fetch_pc),
    .fetch_pred_next   (fetch_pred_next),
    .fetch_branch_jump (fetch_branch_jump),
    .fetch_epoch       (fetch_epoch)
  );

  task automatic push_exp(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] pn, input logic bj, input logic [1:0] ep);
    exp_t e;
    e.v = v; e.pc = pc; e.pn = pn; e.bj = bj; e.ep = ep;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty got=%0d want=1", exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    total++;
    assert (fetch_valid === e.v) else begin
      bad++; $error("FAIL %s.valid got=%0b want=%0b", t, fetch_valid, e.v);
    end
    total++;
    assert (fetch_pc === e.pc) else begin
      bad++; $error("FAIL %s.pc got=%h want=%h", t, fetch_pc, e.pc);
    end
    total++;
    assert (fetch_pred_next === e.pn) else begin
      bad++; $error("FAIL %s.pred got=%h want=%h", t, fetch_pred_next, e.pn);
    end
    total++;
    assert (fetch_branch_jump === e.bj) else begin
      bad++; $error("FAIL %s.bj got=%0b want=%0b", t, fetch_branch_jump, e.bj);
    end
    total++;
    assert (fetch_epoch === e.ep) else begin
      bad++; $error("FAIL %s.epoch got=%0d want=%0d", t, fetch_epoch, e.ep);
    end
  endtask

  // One clock with a plain (no BTB hit) expectation for the state after the edge.
  task automatic step(input string tag, input logic [31:0] pc, input logic [1:0] ep);
    logic [31:0] pn;
    pn = pc + 32'd4;
    push_exp(tag, 1'b1, pc, pn, 1'b0, ep);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic clear_flush();
    ex_flush  = '0;
    dec_flush = '0;
  endtask

  initial begin
    rst = 1'b0; clk_en = 1'b1; stall = 1'b0; fetch_ready = 1'b1;
    ex_flush = '0; dec_flush = '0; dec_pc = 32'h0; dec_is_jump = 1'b0;
    #2;
    push_exp("reset", 1'b0, 32'h0, 32'h4, 1'b0, 2'd0);
    check_out();
    #5;
    rst = 1'b1;

    // Reset release and streaming
    step("boot0", 32'h0, 2'd0);
    step("boot1", 32'h4, 2'd0);
    step("boot2", 32'h8, 2'd0);

    // Back-pressure from imem holds the request
    fetch_ready = 1'b0;
    step("hold0", 32'h8, 2'd0);
    step("hold1", 32'h8, 2'd0);
    step("hold2", 32'h8, 2'd0);
    fetch_ready = 1'b1;
    step("resume", 32'hC, 2'd0);

    // Simultaneous flushes: back end wins, address aligned, single epoch bump
    ex_flush  = '{valid: 1'b1, address: 32'h103};
    dec_flush = '{valid: 1'b1, address: 32'h200};
    step("both_flush", 32'h100, 2'd1);
    clear_flush();

    // Stall blocks advance
    stall = 1'b1;
    step("stall", 32'h100, 2'd1);
    stall = 1'b0;

    // clk_en low: dec then ex parked, ex wins on re-enable
    clk_en = 1'b0;
    dec_flush = '{valid: 1'b1, address: 32'h40};
    step("gated_dec", 32'h100, 2'd1);
    dec_flush = '0;
    ex_flush  = '{valid: 1'b1, address: 32'h80};
    step("gated_ex", 32'h100, 2'd1);
    clear_flush();
    clk_en = 1'b1;
    step("pend_ex", 32'h80, 2'd2);
    step("pend_done", 32'h84, 2'd2);

    // clk_en low: parked ex is not displaced by a later dec
    clk_en = 1'b0;
    ex_flush = '{valid: 1'b1, address: 32'h500};
    step("gated_ex2", 32'h84, 2'd2);
    ex_flush  = '0;
    dec_flush = '{valid: 1'b1, address: 32'h600};
    step("gated_dec2", 32'h84, 2'd2);
    clear_flush();
    clk_en = 1'b1;
    step("pend_ex2", 32'h500, 2'd3);

    // Address wrap with epoch wrap 3 -> 0
    ex_flush = '{valid: 1'b1, address: 32'hFFFF_FFFF};
    push_exp("top_addr", 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    check_out();
    clear_flush();
    step("wrap", 32'h0, 2'd0);

    // Decode redirect alone
    dec_flush = '{valid: 1'b1, address: 32'h22};
    step("dec_only", 32'h20, 2'd1);
    clear_flush();

`ifdef FETCH_BTB_EN
    // BTB training and lookup
    dec_flush = '{valid: 1'b1, address: 32'h300};
    dec_pc = 32'h10; dec_is_jump = 1'b1;
    step("btb_train", 32'h300, 2'd2);
    clear_flush();
    dec_is_jump = 1'b0;
    ex_flush = '{valid: 1'b1, address: 32'h10};
    push_exp("btb_hit", 1'b1, 32'h10, 32'h300, 1'b1, 2'd3);
    @(posedge clk);
    #1;
    check_out();
    clear_flush();
    dec_flush = '{valid: 1'b1, address: 32'h14};
    dec_pc = 32'h10; dec_is_jump = 1'b0;
    step("btb_clear", 32'h14, 2'd0);
    clear_flush();
    ex_flush = '{valid: 1'b1, address: 32'h10};
    step("btb_miss", 32'h10, 2'd1);
    clear_flush();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
